// File: rtl/execute_pipe.sv
// EX stage: single-cycle ALU with a valid/ready output slot, plus an iterative
// shift-add unsigned multiplier that writes HI/LO and emits LO as one beat.
//
//   state | meaning
//   IDLE  | accepting beats; ALU results registered on the accepting edge
//   MUL   | multu in progress, MUL_STEP multiplier bits retired per cycle
module execute_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_STEP   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     rs_data,
  input  logic [DATA_W-1:0]     rt_data,
  input  logic [DATA_W-1:0]     imm_ext,
  input  logic [DATA_W-1:0]     next_pc,
  input  logic [1:0]            alu_op,
  input  logic                  alu_src,
  input  logic                  reg_dst,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     alu_result,
  output logic [DATA_W-1:0]     branch_target,
  output logic                  zero,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic                  busy
);

  localparam int STEPS = DATA_W / MUL_STEP;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SUM_W = DATA_W + MUL_STEP;

  typedef enum logic {IDLE, MUL} state_t;
  state_t state;

  logic [DATA_W-1:0]     op_b, alu_res, hi, lo, mcand;
  logic [5:0]            funct;
  logic [4:0]            shamt;
  logic                  shift_oor, is_multu, zero_d;
  logic [REG_ADDR_W-1:0] dst;
  logic [CNT_W-1:0]      cnt;
  logic [2*DATA_W-1:0]   prod, prod_nxt;
  logic [SUM_W-1:0]      step_sum;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign funct     = imm_ext[5:0];
  assign shamt     = 5'(imm_ext >> 6);
  assign shift_oor = {27'd0, shamt} >= DATA_W;
  assign op_b      = alu_src ? imm_ext : rt_data;

  always_comb begin
    alu_res  = '0;
    zero_d   = 1'b0;
    is_multu = 1'b0;
    case (alu_op)
      2'b00, 2'b11: alu_res = rs_data + op_b;
      2'b01: begin
        alu_res = rs_data - op_b;
        zero_d  = (rs_data == rt_data);
      end
      default: begin
        case (funct)
          6'b100000: alu_res = rs_data + op_b;
          6'b100010: alu_res = rs_data - op_b;
          6'b100100: alu_res = rs_data & op_b;
          6'b100101: alu_res = rs_data | op_b;
          6'b101010: alu_res = DATA_W'($signed(rs_data) < $signed(op_b));
          6'b101011: alu_res = DATA_W'(rs_data < op_b);
          6'b000000: alu_res = shift_oor ? '0 : (rt_data << shamt);
          6'b000010: alu_res = shift_oor ? '0 : (rt_data >> shamt);
          6'b010000: alu_res = hi;
          6'b010010: alu_res = lo;
          6'b011001: is_multu = 1'b1;
          default:   alu_res = '0;
        endcase
      end
    endcase
    dst = is_multu ? '0 : (reg_dst ? rd_addr : rt_addr);
  end

  // prod holds {partial product, unretired multiplier bits}; each step adds
  // mcand times the low MUL_STEP bits into the top half and shifts right.
  assign step_sum = {{MUL_STEP{1'b0}}, prod[2*DATA_W-1:DATA_W]}
                  + SUM_W'(mcand) * SUM_W'(prod[MUL_STEP-1:0]);
  assign prod_nxt = (2*DATA_W)'({step_sum, prod[DATA_W-1:0]} >> MUL_STEP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      alu_result     <= '0;
      branch_target  <= '0;
      zero           <= 1'b0;
      write_register <= '0;
      hi             <= '0;
      lo             <= '0;
      cnt            <= '0;
      mcand          <= '0;
      prod           <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            branch_target <= next_pc + (imm_ext << 2);
            if (is_multu) begin
              state <= MUL;
              busy  <= 1'b1;
              cnt   <= CNT_W'(STEPS - 1);
              mcand <= rs_data;
              prod  <= {{DATA_W{1'b0}}, rt_data};
            end else begin
              alu_result     <= alu_res;
              zero           <= zero_d;
              write_register <= dst;
              out_valid      <= 1'b1;
            end
          end
        end
        MUL: begin
          if (cnt != '0) begin
            prod <= prod_nxt;
            cnt  <= cnt - CNT_W'(1);
          end else if (!out_valid || out_ready) begin
            // final step completes only once the output slot is free
            hi             <= prod_nxt[2*DATA_W-1:DATA_W];
            lo             <= prod_nxt[DATA_W-1:0];
            alu_result     <= prod_nxt[DATA_W-1:0];
            zero           <= 1'b0;
            write_register <= '0;
            out_valid      <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: a 32-bit instance for the main datapath,
// handshake and multiply, and a 16-bit MUL_STEP=2 instance for shift bounds.
module tb_execute_pipe;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, alu_src, reg_dst, out_valid, out_ready, zero, busy;
  logic [31:0] rs_data, rt_data, imm_ext, next_pc, alu_result, branch_target;
  logic [1:0]  alu_op;
  logic [4:0]  rt_addr, rd_addr, write_register;

  logic        s_in_valid, s_in_ready, s_alu_src, s_reg_dst, s_out_valid, s_out_ready, s_zero, s_busy;
  logic [15:0] s_rs_data, s_rt_data, s_imm_ext, s_next_pc, s_alu_result, s_branch_target;
  logic [1:0]  s_alu_op;
  logic [4:0]  s_rt_addr, s_rd_addr, s_write_register;

  int n_assert = 0;
  int n_fail   = 0;

  execute_pipe #(.DATA_W(32), .REG_ADDR_W(5), .MUL_STEP(1)) u32 (
    .clk(clk), .reset(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext), .next_pc(next_pc),
    .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .branch_target(branch_target), .zero(zero),
    .write_register(write_register), .busy(busy)
  );

  execute_pipe #(.DATA_W(16), .REG_ADDR_W(5), .MUL_STEP(2)) u16 (
    .clk(clk), .reset(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .rs_data(s_rs_data), .rt_data(s_rt_data), .imm_ext(s_imm_ext), .next_pc(s_next_pc),
    .alu_op(s_alu_op), .alu_src(s_alu_src), .reg_dst(s_reg_dst), .rt_addr(s_rt_addr),
    .rd_addr(s_rd_addr), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .alu_result(s_alu_result), .branch_target(s_branch_target), .zero(s_zero),
    .write_register(s_write_register), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input logic [1:0] op, input logic src, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] imm, input logic [31:0] pc,
                          input logic rdst, input logic [4:0] rta, input logic [4:0] rda);
    alu_op = op; alu_src = src; rs_data = rs; rt_data = rt; imm_ext = imm;
    next_pc = pc; reg_dst = rdst; rt_addr = rta; rd_addr = rda; in_valid = 1'b1;
  endtask

  task automatic beat(input logic [1:0] op, input logic src, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [31:0] imm, input logic [31:0] pc,
                      input logic rdst, input logic [4:0] rta, input logic [4:0] rda);
    set_beat(op, src, rs, rt, imm, pc, rdst, rta, rda);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] rd);
    beat(2'b10, 1'b0, rs, rt, {21'd0, sh, fn}, 32'd0, 1'b1, 5'd0, rd);
  endtask

  task automatic rtype16(input logic [5:0] fn, input logic [4:0] sh, input logic [15:0] rs,
                         input logic [15:0] rt, input logic [4:0] rd);
    s_alu_op = 2'b10; s_alu_src = 1'b0; s_rs_data = rs; s_rt_data = rt;
    s_imm_ext = {5'd0, sh, fn}; s_next_pc = 16'd0; s_reg_dst = 1'b1;
    s_rt_addr = 5'd0; s_rd_addr = rd; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic saw;

    reset_n = 1'b0;
    in_valid = 0; alu_op = 0; alu_src = 0; reg_dst = 0; rs_data = 0; rt_data = 0;
    imm_ext = 0; next_pc = 0; rt_addr = 0; rd_addr = 0; out_ready = 1'b1;
    s_in_valid = 0; s_alu_op = 0; s_alu_src = 0; s_reg_dst = 0; s_rs_data = 0; s_rt_data = 0;
    s_imm_ext = 0; s_next_pc = 0; s_rt_addr = 0; s_rd_addr = 0; s_out_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", alu_result, 0);
    chk("rst_btarget", branch_target, 0);
    chk("rst_wreg", write_register, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // add via funct
    beat(2'b10, 1'b0, 32'd5, 32'd7, 32'h20, 32'h0, 1'b1, 5'd9, 5'd3);
    chk("add_valid", out_valid, 1);
    chk("add_result", alu_result, 12);
    chk("add_wreg", write_register, 3);
    chk("add_btarget", branch_target, 32'h80);

    // beq taken, negative offset
    beat(2'b01, 1'b0, 32'd9, 32'd9, 32'hFFFF_FFFF, 32'h100, 1'b0, 5'd4, 5'd0);
    chk("beq_zero", zero, 1);
    chk("beq_btarget", branch_target, 32'hFC);
    chk("beq_result", alu_result, 0);
    chk("beq_wreg", write_register, 4);

    beat(2'b00, 1'b0, 32'd4, 32'd4, 32'd0, 32'd0, 1'b0, 5'd2, 5'd0);
    chk("add00_result", alu_result, 8);
    chk("add00_zero", zero, 0);

    rtype(6'b100010, 5'd0, 32'd3, 32'd5, 5'd1);
    chk("sub_wrap", alu_result, 32'hFFFF_FFFE);
    rtype(6'b100100, 5'd0, 32'hF0F0, 32'hFF00, 5'd1);
    chk("and", alu_result, 32'hF000);
    rtype(6'b100101, 5'd0, 32'hF0F0, 32'hFF00, 5'd1);
    chk("or", alu_result, 32'hFFF0);
    rtype(6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, 5'd1);
    chk("slt_signed", alu_result, 1);
    rtype(6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1, 5'd1);
    chk("sltu", alu_result, 0);
    rtype(6'b000010, 5'd31, 32'd0, 32'h8000_0000, 5'd1);
    chk("srl31", alu_result, 1);
    rtype(6'b000000, 5'd4, 32'd0, 32'd3, 5'd1);
    chk("sll4", alu_result, 32'h30);

    // addi, negative immediate
    beat(2'b11, 1'b1, 32'd10, 32'd0, 32'hFFFF_FFFB, 32'd0, 1'b0, 5'd8, 5'd0);
    chk("addi_result", alu_result, 5);
    chk("addi_wreg", write_register, 8);
    rtype(6'b111111, 5'd0, 32'd5, 32'd7, 5'd1);
    chk("undef32", alu_result, 0);

    // multu 0xFFFFFFFF * 2
    rtype(6'b011001, 5'd0, 32'hFFFF_FFFF, 32'd2, 5'd9);
    chk("mul_busy", busy, 1);
    chk("mul_in_ready", in_ready, 0);
    cyc = 0; saw = 1'b0;
    while (busy && cyc < 100) begin
      cyc++;
      if (in_ready) saw = 1'b1;
      @(negedge clk);
    end
    chk("mul_cycles", cyc, 32);
    chk("mul_ready_seen", saw, 0);
    chk("mul_valid", out_valid, 1);
    chk("mul_lo", alu_result, 32'hFFFF_FFFE);
    chk("mul_wreg", write_register, 0);
    chk("mul_zero", zero, 0);
    rtype(6'b010000, 5'd0, 32'd0, 32'd0, 5'd7);
    chk("mfhi", alu_result, 1);
    chk("mfhi_wreg", write_register, 7);
    rtype(6'b010010, 5'd0, 32'd0, 32'd0, 5'd7);
    chk("mflo", alu_result, 32'hFFFF_FFFE);

    // backpressure: A held three cycles while B waits
    rtype(6'b100000, 5'd0, 32'd1, 32'd2, 5'd5);
    out_ready = 1'b0;
    set_beat(2'b10, 1'b0, 32'd10, 32'd20, 32'h20, 32'd0, 1'b1, 5'd0, 5'd6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", alu_result, 3);
      chk("hold_wreg", write_register, 5);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b_valid", out_valid, 1);
    chk("b_result", alu_result, 30);
    chk("b_wreg", write_register, 6);
    @(negedge clk);
    chk("b_retired", out_valid, 0);

    // reset during multiply
    rtype(6'b011001, 5'd0, 32'd5, 32'd7, 5'd0);
    repeat (10) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("no_spurious", saw, 0);
    chk("abort_in_ready", in_ready, 1);
    rtype(6'b010010, 5'd0, 32'd0, 32'd0, 5'd2);
    chk("mflo_after_rst", alu_result, 0);
    chk("mflo_rst_valid", out_valid, 1);
    chk("mflo_rst_wreg", write_register, 2);
    rtype(6'b010000, 5'd0, 32'd0, 32'd0, 5'd2);
    chk("mfhi_after_rst", alu_result, 0);

    // 16-bit instance: shift bounds, undefined funct, 2-bit-per-cycle multiply
    rtype16(6'b000000, 5'd3, 16'd0, 16'd1, 5'd1);
    chk("s_sll3", s_alu_result, 8);
    rtype16(6'b000000, 5'd31, 16'd0, 16'd1, 5'd1);
    chk("s_sll31", s_alu_result, 0);
    rtype16(6'b000010, 5'd15, 16'd0, 16'h8000, 5'd1);
    chk("s_srl15", s_alu_result, 1);
    rtype16(6'b000010, 5'd16, 16'd0, 16'h8000, 5'd1);
    chk("s_srl16", s_alu_result, 0);
    rtype16(6'b100000, 5'd0, 16'd1, 16'd1, 5'd1);
    chk("s_add", s_alu_result, 2);
    rtype16(6'b111111, 5'd0, 16'd5, 16'd7, 5'd1);
    chk("s_undef", s_alu_result, 0);
    rtype16(6'b011001, 5'd0, 16'hFFFF, 16'hFFFF, 5'd1);
    cyc = 0;
    while (s_busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("s_mul_cycles", cyc, 8);
    chk("s_mul_lo", s_alu_result, 16'h0001);
    rtype16(6'b010000, 5'd0, 16'd0, 16'd0, 5'd1);
    chk("s_mfhi", s_alu_result, 16'hFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
